// File: rtl/key_press_gen.sv
// Push-button emulator: turns a key command into a timed active-low press
// followed by a fixed release gap, with done/err completion pulses.
module key_press_gen #(
    parameter int HOLD_W     = 16,
    parameter int GAP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_code,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              abort,
    output logic [7:0]        key,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // One counter serves both phases, so it must fit either the hold or the gap.
    localparam int CNT_W = (HOLD_W > 16) ? HOLD_W : 16;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hold_load;
    logic [7:0]       press_key;

    // Counter holds "cycles remaining minus one"; a zero hold still gives one cycle.
    always_comb begin
        hold_load = '0;
        if (cmd_hold != '0)
            hold_load = CNT_W'(cmd_hold) - CNT_W'(1);
    end

    always_comb begin
        press_key = '1;
        case (cmd_code)
            4'd14:   press_key = 8'hFE;
            4'd13:   press_key = 8'hFD;
            4'd12:   press_key = 8'hFB;
            4'd11:   press_key = 8'hF7;
            4'd10:   press_key = 8'hEF;
            4'd9:    press_key = 8'hDF;
            4'd8:    press_key = 8'hBF;
            4'd7:    press_key = 8'h7F;
            default: press_key = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            key   <= '1;
            done  <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_code == 4'hF) begin
                            done <= 1'b1;
                        end else if (cmd_code < 4'd7) begin
                            err <= 1'b1;
                        end else begin
                            key   <= press_key;
                            cnt   <= hold_load;
                            state <= PRESS;
                        end
                    end
                end
                PRESS: begin
                    if (abort) begin
                        key   <= '1;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        key   <= '1;
                        cnt   <= GAP_LOAD;
                        state <= GAP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (abort) begin
                        key   <= '1;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    key   <= '1;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule
